// File: rtl/ultrasonic_pkg.sv
// rtl/ultrasonic_pkg.sv - shared FSM encoding and tick constants for the ultrasonic scheduler
package ultrasonic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_TRIG,
    ST_WAIT_RISE,
    ST_MEASURE,
    ST_STORE,
    ST_GUARD
  } us_state_t;

  localparam logic [15:0] ECHO_SAT = 16'hFFFF;

  localparam int DEF_CLK_DIV        = 50;
  localparam int DEF_TRIG_TICKS     = 10;
  localparam int DEF_RISE_TMO_TICKS = 30000;
  localparam int DEF_GUARD_TICKS    = 60000;
  localparam int DEF_SAT_TICKS      = 65535;

endpackage

// File: rtl/us_rr_pick.sv
// rtl/us_rr_pick.sv - combinational round-robin picker: first set mask bit after cur, with wrap
module us_rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         mask,
  input  logic [$clog2(N)-1:0] cur,
  output logic [$clog2(N)-1:0] next,
  output logic                 found
);
  localparam int W = $clog2(N);

  logic [W-1:0] idx;

  // i runs to N so that a lone enabled channel picks itself again
  always_comb begin
    next  = cur;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= N; i++) begin
      idx = W'((int'(cur) + i) % N);
      if (!found && mask[idx]) begin
        next  = idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ultrasonic_scheduler.sv
// rtl/ultrasonic_scheduler.sv - round-robin HC-SR04 sequencer: trigger, time echo, store, guard
module ultrasonic_scheduler
  import ultrasonic_pkg::*;
#(
  parameter int N_SENS         = 4,
  parameter int CLK_DIV        = DEF_CLK_DIV,
  parameter int TRIG_TICKS     = DEF_TRIG_TICKS,
  parameter int RISE_TMO_TICKS = DEF_RISE_TMO_TICKS,
  parameter int GUARD_TICKS    = DEF_GUARD_TICKS,
  parameter int SAT_TICKS      = DEF_SAT_TICKS
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic [N_SENS-1:0]         sensor_mask,
  input  logic [N_SENS-1:0]         echo,
  output logic [N_SENS-1:0]         trig,
  input  logic [$clog2(N_SENS)-1:0] rd_sel,
  output logic [15:0]               rd_value,
  output logic                      rd_valid,
  output logic                      rd_new,
  output logic                      rd_timeout,
  input  logic                      rd_ack,
  output logic                      busy,
  output logic [$clog2(N_SENS)-1:0] cur_sensor,
  output logic                      sample_done
);
  localparam int IDX_W  = $clog2(N_SENS);
  localparam int BANK_N = 1 << IDX_W;
  localparam int PRE_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  us_state_t         state;
  logic [PRE_W-1:0]  pre_cnt;
  logic [15:0]       tick_cnt;
  logic [15:0]       meas_value;
  logic              meas_tmo;
  logic [N_SENS-1:0] echo_s1, echo_s2;
  logic              echo_d, echo_cur, echo_rise, echo_fall;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_found;
  logic              wrap, trig_hit, rise_hit, sat_hit, guard_hit;

  logic [15:0]       bank_value [BANK_N];
  logic [BANK_N-1:0] bank_valid, bank_new, bank_tmo;

  us_rr_pick #(.N(N_SENS)) u_pick (
    .mask  (sensor_mask),
    .cur   (cur_sensor),
    .next  (pick_idx),
    .found (pick_found)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      echo_s1 <= '0;
      echo_s2 <= '0;
      echo_d  <= 1'b0;
    end else begin
      echo_s1 <= echo;
      echo_s2 <= echo_s1;
      echo_d  <= echo_cur;
    end
  end

  assign echo_cur  = echo_s2[cur_sensor];
  assign echo_rise = echo_cur & ~echo_d;
  assign echo_fall = ~echo_cur & echo_d;

  // a "hit" fires on the cycle that completes the n-th tick of the current state
  assign wrap      = (pre_cnt == PRE_W'(CLK_DIV - 1));
  assign trig_hit  = wrap && (tick_cnt == 16'(TRIG_TICKS - 1));
  assign rise_hit  = wrap && (tick_cnt == 16'(RISE_TMO_TICKS - 1));
  assign sat_hit   = wrap && (tick_cnt == 16'(SAT_TICKS - 1));
  assign guard_hit = wrap && (tick_cnt == 16'(GUARD_TICKS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cur_sensor  <= IDX_W'(N_SENS - 1);
      trig        <= '0;
      sample_done <= 1'b0;
      pre_cnt     <= '0;
      tick_cnt    <= '0;
      meas_value  <= '0;
      meas_tmo    <= 1'b0;
    end else begin
      sample_done <= 1'b0;
      pre_cnt     <= wrap ? '0 : pre_cnt + 1'b1;
      if (wrap) tick_cnt <= tick_cnt + 16'd1;
      case (state)
        ST_IDLE: begin
          if (enable && |sensor_mask) begin
            state    <= ST_SELECT;
            pre_cnt  <= '0;
            tick_cnt <= '0;
          end
        end
        ST_SELECT: begin
          pre_cnt  <= '0;
          tick_cnt <= '0;
          if (enable && pick_found) begin
            cur_sensor <= pick_idx;
            trig       <= N_SENS'(1) << pick_idx;
            state      <= ST_TRIG;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_TRIG: begin
          if (trig_hit) begin
            trig     <= '0;
            state    <= ST_WAIT_RISE;
            pre_cnt  <= '0;
            tick_cnt <= '0;
          end
        end
        ST_WAIT_RISE: begin
          if (echo_rise) begin
            state    <= ST_MEASURE;
            pre_cnt  <= '0;
            tick_cnt <= '0;
          end else if (rise_hit) begin
            meas_value  <= ECHO_SAT;
            meas_tmo    <= 1'b1;
            sample_done <= 1'b1;
            state       <= ST_STORE;
            pre_cnt     <= '0;
            tick_cnt    <= '0;
          end
        end
        ST_MEASURE: begin
          // the +1 counts the partial tick in flight so the result never reads short
          if (echo_fall) begin
            meas_value  <= tick_cnt + 16'd1;
            meas_tmo    <= 1'b0;
            sample_done <= 1'b1;
            state       <= ST_STORE;
            pre_cnt     <= '0;
            tick_cnt    <= '0;
          end else if (sat_hit) begin
            meas_value  <= ECHO_SAT;
            meas_tmo    <= 1'b1;
            sample_done <= 1'b1;
            state       <= ST_STORE;
            pre_cnt     <= '0;
            tick_cnt    <= '0;
          end
        end
        ST_STORE: begin
          state    <= ST_GUARD;
          pre_cnt  <= '0;
          tick_cnt <= '0;
        end
        ST_GUARD: begin
          if (!enable) begin
            state    <= ST_IDLE;
            pre_cnt  <= '0;
            tick_cnt <= '0;
          end else if (guard_hit) begin
            state    <= ST_SELECT;
            pre_cnt  <= '0;
            tick_cnt <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);

  // the STORE write comes after the ack clear, so a same-index collision keeps new set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BANK_N; i++) bank_value[i] <= '0;
      bank_valid <= '0;
      bank_new   <= '0;
      bank_tmo   <= '0;
    end else begin
      if (rd_ack) bank_new[rd_sel] <= 1'b0;
      if (state == ST_STORE) begin
        bank_value[cur_sensor] <= meas_value;
        bank_tmo[cur_sensor]   <= meas_tmo;
        bank_valid[cur_sensor] <= 1'b1;
        bank_new[cur_sensor]   <= 1'b1;
      end
    end
  end

  assign rd_value   = bank_value[rd_sel];
  assign rd_valid   = bank_valid[rd_sel];
  assign rd_new     = bank_new[rd_sel];
  assign rd_timeout = bank_tmo[rd_sel];

endmodule

// File: tb/tb_ultrasonic_scheduler.sv
// tb/tb_ultrasonic_scheduler.sv - vector table plus scoreboard bench for ultrasonic_scheduler
module tb_ultrasonic_scheduler;

  localparam int N        = 4;
  localparam int D        = 4;
  localparam int TRIG_T   = 10;
  localparam int RISE_T   = 100;
  localparam int GUARD_T  = 20;
  localparam int SAT_T    = 400;
  localparam int TRIG_CYC = TRIG_T * D;

  typedef enum int {M_NORMAL, M_NEVER, M_STUCK} mode_e;
  typedef struct {
    mode_e       mode;
    int          delay;
    int          width;
    logic [15:0] exp_value;
    logic        exp_tmo;
  } vec_t;
  typedef struct {
    int          ch;
    logic [15:0] value;
    logic        tmo;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [3:0]  sensor_mask;
  logic [3:0]  echo;
  logic [3:0]  trig;
  logic [1:0]  rd_sel;
  logic [15:0] rd_value;
  logic        rd_valid, rd_new, rd_timeout, rd_ack;
  logic        busy;
  logic [1:0]  cur_sensor;
  logic        sample_done;

  vec_t vecs [8];
  vec_t plan [N];
  exp_t sb_q [$];
  int   trig_ch_q [$];
  int   trig_len_q [$];
  int   order_exp [6];
  int   errors = 0;
  int   checks = 0;
  int   bad_trig = 0;
  int   trig2_cnt = 0;

  ultrasonic_scheduler #(
    .N_SENS(N), .CLK_DIV(D), .TRIG_TICKS(TRIG_T), .RISE_TMO_TICKS(RISE_T),
    .GUARD_TICKS(GUARD_T), .SAT_TICKS(SAT_T)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sensor_mask(sensor_mask), .echo(echo),
    .trig(trig), .rd_sel(rd_sel), .rd_value(rd_value), .rd_valid(rd_valid), .rd_new(rd_new),
    .rd_timeout(rd_timeout), .rd_ack(rd_ack), .busy(busy), .cur_sensor(cur_sensor),
    .sample_done(sample_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if ($countones(trig) > 1) bad_trig++;
    if (trig[2]) trig2_cnt++;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input longint act, input longint lo, input longint hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic wait_sample(input string tag, input int budget, output bit ok);
    int n;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < budget) begin
      @(negedge clk);
      if (sample_done) ok = 1'b1;
      n++;
    end
    if (!ok) chk({tag, "_sample_timeout"}, 0, 1);
  endtask

  task automatic check_result(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 0, 1);
      return;
    end
    e = sb_q.pop_front();
    chk({tag, "_channel"}, cur_sensor, e.ch);
    @(negedge clk);
    chk({tag, "_done_pulse"}, sample_done, 0);
    rd_sel = 2'(e.ch);
    #1;
    chk({tag, "_valid"}, rd_valid, 1);
    chk({tag, "_new"}, rd_new, 1);
    chk({tag, "_timeout"}, rd_timeout, e.tmo);
    if (e.tmo) chk({tag, "_value"}, rd_value, e.value);
    else       chk_range({tag, "_value"}, rd_value, e.value, e.value + 1);
  endtask

  // echo responder: answers each trigger per plan[] and pushes the expected result
  initial begin : responder
    int   ch;
    int   n;
    exp_t e;
    vec_t p;
    echo = '0;
    forever begin
      @(negedge clk);
      if (trig != '0) begin
        ch = 0;
        for (int i = 0; i < N; i++) if (trig[i]) ch = i;
        p = plan[ch];
        trig_ch_q.push_back(ch);
        if (p.mode == M_STUCK) echo[ch] = 1'b1;
        n = 0;
        while (trig != '0 && n < 5000) begin
          n++;
          @(negedge clk);
        end
        trig_len_q.push_back(n);
        if (n == TRIG_CYC) begin
          e.ch    = ch;
          e.value = p.exp_value;
          e.tmo   = p.exp_tmo;
          sb_q.push_back(e);
          if (p.mode == M_NORMAL) begin
            repeat (p.delay * D) @(negedge clk);
            echo[ch] = 1'b1;
            repeat (p.width * D) @(negedge clk);
            echo[ch] = 1'b0;
          end else if (p.mode == M_STUCK) begin
            n = 0;
            while (!sample_done && n < 5000) begin
              n++;
              @(negedge clk);
            end
            @(negedge clk);
            echo[ch] = 1'b0;
          end
        end else begin
          echo[ch] = 1'b0;
        end
      end
    end
  end

  initial begin : main
    bit   ok;
    exp_t e;
    int   cnt;
    int   other;

    vecs[0] = '{M_NORMAL, 1,   100,        16'd100,   1'b0};
    vecs[1] = '{M_NORMAL, 3,   1,          16'd1,     1'b0};
    vecs[2] = '{M_NEVER,  0,   0,          16'hFFFF,  1'b1};
    vecs[3] = '{M_NORMAL, 2,   37,         16'd37,    1'b0};
    vecs[4] = '{M_STUCK,  0,   0,          16'hFFFF,  1'b1};
    vecs[5] = '{M_NORMAL, 1,   SAT_T + 5,  16'hFFFF,  1'b1};
    vecs[6] = '{M_NORMAL, 95,  10,         16'd10,    1'b0};
    vecs[7] = '{M_NORMAL, 1,   250,        16'd250,   1'b0};
    order_exp = '{0, 1, 3, 0, 1, 3};
    for (int i = 0; i < N; i++) plan[i] = '{M_NORMAL, 1, 20, 16'd20, 1'b0};

    rst_n       = 1'b0;
    enable      = 1'b1;
    sensor_mask = 4'b0001;
    rd_sel      = '0;
    rd_ack      = 1'b0;
    plan[0]     = vecs[0];
    repeat (3) @(negedge clk);
    #1;
    chk("rst_trig", trig, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", sample_done, 0);
    chk("rst_cur", cur_sensor, 3);
    chk("rst_valid", rd_valid, 0);
    chk("rst_new", rd_new, 0);
    chk("rst_timeout", rd_timeout, 0);
    chk("rst_value", rd_value, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // single channel: each vector is one full trigger/echo/store round on channel 0
    for (int i = 0; i < 8; i++) begin
      plan[0] = vecs[i];
      wait_sample($sformatf("vec%0d", i), 3000, ok);
      if (ok) check_result($sformatf("vec%0d", i));
    end
    chk("vec_trig_count", trig_len_q.size(), 8);
    for (int i = 0; i < trig_len_q.size(); i++) begin
      chk($sformatf("vec_trig_len%0d", i), trig_len_q[i], TRIG_CYC);
      chk($sformatf("vec_trig_ch%0d", i), trig_ch_q[i], 0);
    end

    // reset while a trigger pulse is out
    plan[0] = '{M_NORMAL, 1, 20, 16'd20, 1'b0};
    cnt = 0;
    while (trig == '0 && cnt < 500) begin
      @(negedge clk);
      cnt++;
    end
    chk("mid_trig_seen", (trig != '0), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_trig", trig, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_cur", cur_sensor, 3);
    for (int s = 0; s < N; s++) begin
      rd_sel = 2'(s);
      #1;
      chk($sformatf("mid_rst_valid%0d", s), rd_valid, 0);
      chk($sformatf("mid_rst_new%0d", s), rd_new, 0);
      chk($sformatf("mid_rst_value%0d", s), rd_value, 0);
    end
    repeat (3) @(negedge clk);
    sensor_mask = 4'b1011;
    plan[0] = '{M_NORMAL, 1, 30, 16'd30,   1'b0};
    plan[1] = '{M_NEVER,  0, 0,  16'hFFFF, 1'b1};
    plan[3] = '{M_NORMAL, 1, 60, 16'd60,   1'b0};
    sb_q.delete();
    trig_ch_q.delete();
    trig_len_q.delete();
    rst_n = 1'b1;

    // rotation over mask 1011, channel 1 never answers
    for (int k = 0; k < 6; k++) begin
      wait_sample($sformatf("rr%0d", k), 3000, ok);
      if (ok) check_result($sformatf("rr%0d", k));
    end
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("rr_order%0d", k), (k < trig_ch_q.size()) ? trig_ch_q[k] : -1, order_exp[k]);
      chk($sformatf("rr_len%0d", k), (k < trig_len_q.size()) ? trig_len_q[k] : -1, TRIG_CYC);
    end

    // enable dropped mid-measure, ack colliding with the store
    for (int i = 0; i < N; i++) plan[i] = '{M_NORMAL, 1, 100, 16'd100, 1'b0};
    cnt = 0;
    while (echo == '0 && cnt < 3000) begin
      @(negedge clk);
      cnt++;
    end
    chk("drop_echo_seen", (echo != '0), 1);
    repeat (10) @(negedge clk);
    enable = 1'b0;
    wait_sample("drop", 3000, ok);
    if (ok && sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk("drop_channel", cur_sensor, e.ch);
      rd_sel = 2'(e.ch);
      rd_ack = 1'b1;
      @(negedge clk);
      rd_ack = 1'b0;
      #1;
      chk("drop_new_kept", rd_new, 1);
      chk("drop_valid", rd_valid, 1);
      chk("drop_timeout", rd_timeout, 0);
      chk_range("drop_value", rd_value, 100, 101);
      @(negedge clk);
      #1;
      chk("drop_busy", busy, 0);
      other = (e.ch == 0) ? 3 : 0;
      rd_sel = 2'(other);
      rd_ack = 1'b1;
      @(negedge clk);
      rd_ack = 1'b0;
      #1;
      chk("ack_other_cleared", rd_new, 0);
      rd_sel = 2'(e.ch);
      #1;
      chk("ack_other_untouched", rd_new, 1);
      rd_ack = 1'b1;
      @(negedge clk);
      rd_ack = 1'b0;
      #1;
      chk("ack_self_cleared", rd_new, 0);
      chk("ack_self_valid", rd_valid, 1);
    end else begin
      chk("drop_sb_nonempty", 0, 1);
    end

    cnt = 0;
    repeat (300) begin
      @(negedge clk);
      if (busy || trig != '0) cnt++;
    end
    chk("idle_stays", cnt, 0);
    chk("sb_drained", sb_q.size(), 0);
    chk("trig_onehot", bad_trig, 0);
    chk("trig2_never", trig2_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
